fb_ddram_wr_arbiter: RTL

- Write scheduler between the rotated-framebuffer pixel path and the DDRAM port.
- Buffers 32-bit pixel writes in a FIFO and runs a framebuffer clear engine.
- Arbitrates both sources onto one 64-bit DDRAM write command, honouring DDRAM_BUSY.
- Sits between the screen rotator's pixel/address output and the top-level DDRAM signals.

---
 rtl/fb_ddram_wr_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fb_ddram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_ddram_wr_arbiter
// Desc     : Pixel write FIFO plus framebuffer clear engine, arbitrated onto a
//            single 64-bit DDRAM write port. Define FB_ARB_COALESCE_EN to merge
//            two half-word pixels of the same 64-bit word into one beat.
// Revision : 1.0
// ============================================================================
module fb_ddram_wr_arbiter #(
  parameter logic [6:0] MEM_BASE   = 7'b0000011,
  parameter int         FIFO_AW    = 4,
  parameter logic [7:0] STARVE_MAX = 8'd64
) (
  input  logic        CLK_VIDEO,
  input  logic        RESET_N,
  input  logic        wr_req,
  input  logic [1:0]  wr_fb,
  input  logic [22:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_ovf,
  input  logic        clr_start,
  input  logic [1:0]  clr_fb,
  input  logic [22:0] clr_size,
  output logic        clr_busy,
  output logic        clr_done,
  input  logic        DDRAM_BUSY,
  output logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic        DDRAM_RD
);

  localparam int               ENTRY_W = 55;  // {fb, addr[22:2], data}
  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0] PTR_TWO = (FIFO_AW+1)'(2);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];

  state_t           state_q, state_d;
  logic [FIFO_AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             ovf_q, ovf_d;
  logic [28:0]      addr_q, addr_d;
  logic [63:0]      din_q, din_d;
  logic [7:0]       be_q, be_d;
  logic             we_q, we_d;
  logic             last_clr_q, last_clr_d;
  logic             clr_busy_q, clr_busy_d, clr_done_q, clr_done_d;
  logic [1:0]       clr_fb_q, clr_fb_d;
  logic [20:0]      clr_ptr_q, clr_ptr_d, clr_words_q, clr_words_d;
  logic [7:0]       starve_q, starve_d;

  logic [FIFO_AW:0] fifo_cnt;
  logic             fifo_empty, push, pair, can_load, accepted, clr_pending, pick_clr;
  logic [1:0]       head_fb;
  logic [20:0]      head_addr;
  logic [31:0]      head_data;
  logic [63:0]      pair_din;
  logic [20:0]      clr_words_new, clr_ptr_inc;
  logic             unused_addr_lsb;

  assign fifo_cnt        = wptr_q - rptr_q;
  assign wr_full         = fifo_cnt[FIFO_AW];
  assign fifo_empty      = (fifo_cnt == '0);
  assign push            = wr_req && !wr_full;
  assign unused_addr_lsb = ^wr_addr[1:0];
  assign {head_fb, head_addr, head_data} = fifo_mem[rptr_q[FIFO_AW-1:0]];

`ifdef FB_ARB_COALESCE_EN
  logic [FIFO_AW-1:0] nxt_idx;
  logic [1:0]         nxt_fb;
  logic [20:0]        nxt_addr;
  logic [31:0]        nxt_data;
  assign nxt_idx = rptr_q[FIFO_AW-1:0] + FIFO_AW'(1);
  assign {nxt_fb, nxt_addr, nxt_data} = fifo_mem[nxt_idx];
  // head_addr[0] is byte-address bit 2, i.e. which 32-bit half of the word
  assign pair = (fifo_cnt > PTR_ONE) && (nxt_fb == head_fb) &&
                (nxt_addr[20:1] == head_addr[20:1]) && (nxt_addr[0] != head_addr[0]);
  assign pair_din = head_addr[0] ? {head_data, nxt_data} : {nxt_data, head_data};
`else
  assign pair     = 1'b0;
  assign pair_din = {head_data, head_data};
`endif

  // Word count rounded up without ever overflowing: floor(size/8) + (size%8 != 0)
  assign clr_words_new = {1'b0, clr_size[22:3]} + {20'd0, |clr_size[2:0]};
  assign clr_ptr_inc   = clr_ptr_q + 21'd1;
  assign can_load      = (state_q == S_IDLE) || !DDRAM_BUSY;
  assign accepted      = (state_q == S_HOLD) && !DDRAM_BUSY;
  assign clr_pending   = clr_busy_q && (clr_ptr_q != clr_words_q);
  assign pick_clr      = clr_pending && (fifo_empty || (starve_q >= STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    ovf_d       = ovf_q;
    addr_d      = addr_q;
    din_d       = din_q;
    be_d        = be_q;
    we_d        = we_q;
    last_clr_d  = last_clr_q;
    clr_busy_d  = clr_busy_q;
    clr_done_d  = 1'b0;
    clr_fb_d    = clr_fb_q;
    clr_ptr_d   = clr_ptr_q;
    clr_words_d = clr_words_q;
    starve_d    = starve_q;

    if (wr_req) begin
      if (wr_full) ovf_d = 1'b1;
      else         wptr_d = wptr_q + PTR_ONE;
    end

    if (accepted && last_clr_q) begin
      clr_busy_d = 1'b0;
      clr_done_d = 1'b1;
    end

    if (can_load) begin
      if (pick_clr) begin
        addr_d     = {MEM_BASE, clr_fb_q, clr_ptr_q[19:0]};
        din_d      = 64'd0;
        be_d       = 8'hFF;
        we_d       = 1'b1;
        state_d    = S_HOLD;
        clr_ptr_d  = clr_ptr_inc;
        last_clr_d = (clr_ptr_inc == clr_words_q);
      end else if (!fifo_empty) begin
        addr_d     = {MEM_BASE, head_fb, head_addr[20:1]};
        we_d       = 1'b1;
        state_d    = S_HOLD;
        last_clr_d = 1'b0;
        if (pair) begin
          din_d  = pair_din;
          be_d   = 8'hFF;
          rptr_d = rptr_q + PTR_TWO;
        end else begin
          din_d  = {head_data, head_data};
          be_d   = head_addr[0] ? 8'hF0 : 8'h0F;
          rptr_d = rptr_q + PTR_ONE;
        end
      end else begin
        we_d       = 1'b0;
        state_d    = S_IDLE;
        last_clr_d = 1'b0;
      end
    end

    if (clr_pending) begin
      if (can_load && pick_clr)       starve_d = 8'd0;
      else if (starve_q < STARVE_MAX) starve_d = starve_q + 8'd1;
    end else begin
      starve_d = 8'd0;
    end

    if (clr_start && !clr_busy_q) begin
      clr_fb_d    = clr_fb;
      clr_words_d = clr_words_new;
      clr_ptr_d   = 21'd0;
      if (clr_words_new == 21'd0) clr_done_d = 1'b1;
      else                        clr_busy_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      last_clr_q  <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      clr_fb_q    <= '0;
      clr_ptr_q   <= '0;
      clr_words_q <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      be_q        <= be_d;
      we_q        <= we_d;
      last_clr_q  <= last_clr_d;
      clr_busy_q  <= clr_busy_d;
      clr_done_q  <= clr_done_d;
      clr_fb_q    <= clr_fb_d;
      clr_ptr_q   <= clr_ptr_d;
      clr_words_q <= clr_words_d;
      starve_q    <= starve_d;
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (push) fifo_mem[wptr_q[FIFO_AW-1:0]] <= {wr_fb, wr_addr[22:2], wr_data};
  end

  assign wr_ovf         = ovf_q;
  assign clr_busy       = clr_busy_q;
  assign clr_done       = clr_done_q;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_WE       = we_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = 1'b0;

endmodule
`default_nettype wire
